execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  RV32I EX stage: takes the ID/EX bundle and computes ALU results and branches.
//  Forwards operands from its own EX/MEM register and from MEM/WB.
//  Resolves branches and drives the redirect to fetch.
//  Owns the EX/MEM pipeline register that feeds the memory stage.
// PARAMETERS
//  XLEN       32  datapath width
//  REG_ADDR_W 5   register index width
// PORTS
//  i_clk                 in   1     clock, rising edge
//  i_reset               in   1     asynchronous, active-high reset
//  i_id_ex_pc            in   XLEN  PC of instruction in EX
//  i_id_ex_instruction   in   32    raw instruction (funct3=[14:12], funct7=[31:25])
//  i_id_ex_read_data1/2  in   XLEN  register-file operands
//  i_id_ex_imm           in   XLEN  sign-extended immediate
//  i_id_ex_rs1/rs2/rd    in   5     register indices
//  i_id_ex_reg_write, _alu_src, _mem_read, _mem_write, _mem_to_reg, _branch  in 1  control
//  i_id_ex_alu_op        in   2     00 add, 01 branch compare, 10 R-type, 11 I-type ALU
//  i_mem_wb_rd           in   5     MEM/WB destination register
//  i_mem_wb_reg_write    in   1     MEM/WB write enable
//  i_mem_wb_write_data   in   XLEN  MEM/WB writeback value
//  o_ex_mem_alu_result   out  XLEN  registered ALU result / memory address
//  o_ex_mem_write_data   out  XLEN  registered forwarded rs2 (store data)
//  o_ex_mem_rd           out  5     registered destination register
//  o_ex_mem_reg_write, _mem_read, _mem_write, _mem_to_reg  out 1  registered control
//  o_branch_taken        out  1     combinational redirect request
//  o_branch_target       out  XLEN  combinational branch target = pc + imm
// BEHAVIOUR
//  Reset: every o_ex_mem_* output = 0 (bubble), asynchronously. EX/MEM loads every i_clk edge; no stall input.
//  Forwarding, operand A (operand B identical using rs2):
//   - EX/MEM (own register) if o_ex_mem_reg_write, o_ex_mem_rd!=0 and o_ex_mem_rd==rs1.
//   - Otherwise MEM/WB if i_mem_wb_reg_write, i_mem_wb_rd!=0 and i_mem_wb_rd==rs1.
//   - Otherwise read_data1. EX/MEM takes priority when both match.
//   - x0 is never forwarded.
//   - Forwarding from an EX/MEM load is illegal; the hazard unit guarantees it does not occur.
//  Operand B = alu_src ? imm : forwarded rs2. Store data always = forwarded rs2.
//  ALU control:
//   - alu_op 00 -> ADD. 01 -> SUB.
//   - alu_op 10 -> decode funct3/funct7[5]: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
//   - alu_op 11 -> funct3; funct7[5] honoured only for SRAI, otherwise ADDI.
//  Shifts use B[4:0]. SLT is signed; SLTU is unsigned. Result = 0/1 zero-extended. Wrap-around add/sub, no traps.
//  Branches:
//   - Taken = branch & cond(funct3).
//   - funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; compares use forwarded operands.
//   - Other funct3 values -> not taken.
//   - o_branch_taken is 0 while branch=0 and during reset.
//  Branch redirect:
//   - Fetch flushes IF/ID and decode bubbles ID/EX on the same edge.
//   - The branch itself enters EX/MEM with reg_write=mem_write=mem_read=0.
//  Latency: 1 cycle ID/EX -> EX/MEM. Branch resolution is same-cycle combinational.
//  Reset mid-operation: the in-flight EX/MEM entry is discarded and no redirect is issued.
// STRUCTURE
//  Shared package (riscv_pkg): ALU_OP_* 2-bit codes; ALU_CTRL_* 4-bit codes; FUNCT3_BEQ..BGEU; FWD_SEL_* (RF, MEM_WB, EX_MEM).
//  One sub-module: alu (combinational; ctrl, a, b -> result), instantiated once.
//  Forwarding mux, ALU control decode, branch compare and EX/MEM register stay in this module.
// TESTING
//  1. Reset asserted with nonzero inputs -> all o_ex_mem_* = 0; o_branch_taken = 0.
//  2. ADD x3,x1,x2 with rd1=5, rd2=7, alu_op=10 -> next edge alu_result=12, rd=3, reg_write=1.
//  3. Back-to-back: ADD x3 (result 12) then SUB x4,x3,x1 (rd1 stale 0, x1=5) -> alu_result=7 via EX/MEM forward.
//  4. MEM/WB and EX/MEM both target x5 (wb=9, exmem=4); ADDI x6,x5,1 -> 5 (EX/MEM wins). rd=0 matches -> no forward.
//  5. BLT with a=-1, b=1, pc=0x100, imm=0x20 -> o_branch_taken=1, target=0x120. BLTU with the same operands -> 0.
//  6. SRA of 0x80000000 by 4 -> 0xF8000000; SRL -> 0x08000000; SLTU 0xFFFFFFFF<1 -> 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I execute-stage definitions: widths, ALU/branch codes and
// forwarding-source selection.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  typedef enum logic [3:0] {
    ALU_CTRL_ADD  = 4'd0,
    ALU_CTRL_SUB  = 4'd1,
    ALU_CTRL_SLL  = 4'd2,
    ALU_CTRL_SLT  = 4'd3,
    ALU_CTRL_SLTU = 4'd4,
    ALU_CTRL_XOR  = 4'd5,
    ALU_CTRL_SRL  = 4'd6,
    ALU_CTRL_SRA  = 4'd7,
    ALU_CTRL_OR   = 4'd8,
    ALU_CTRL_AND  = 4'd9
  } alu_ctrl_e;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    FWD_SEL_RF     = 2'd0,
    FWD_SEL_MEM_WB = 2'd1,
    FWD_SEL_EX_MEM = 2'd2
  } fwd_sel_e;

  // Youngest producer wins; x0 is hard-wired so it is never forwarded.
  function automatic fwd_sel_e fwd_select(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  ex_mem_we,
    input logic [REG_ADDR_W-1:0] ex_mem_rd,
    input logic                  mem_wb_we,
    input logic [REG_ADDR_W-1:0] mem_wb_rd
  );
    fwd_sel_e sel;
    if (rs == {REG_ADDR_W{1'b0}}) begin
      sel = FWD_SEL_RF;
    end else if (ex_mem_we && (ex_mem_rd == rs)) begin
      sel = FWD_SEL_EX_MEM;
    end else if (mem_wb_we && (mem_wb_rd == rs)) begin
      sel = FWD_SEL_MEM_WB;
    end else begin
      sel = FWD_SEL_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX input bundle, MEM/WB forwarding feed and EX/MEM / redirect outputs
// of the execute stage.
interface execute_stage_if;
  import riscv_pkg::*;

  logic [XLEN-1:0]       i_id_ex_pc;
  logic [31:0]           i_id_ex_instruction;
  logic [XLEN-1:0]       i_id_ex_read_data1;
  logic [XLEN-1:0]       i_id_ex_read_data2;
  logic [XLEN-1:0]       i_id_ex_imm;
  logic [REG_ADDR_W-1:0] i_id_ex_rs1;
  logic [REG_ADDR_W-1:0] i_id_ex_rs2;
  logic [REG_ADDR_W-1:0] i_id_ex_rd;
  logic                  i_id_ex_reg_write;
  logic                  i_id_ex_alu_src;
  logic                  i_id_ex_mem_read;
  logic                  i_id_ex_mem_write;
  logic                  i_id_ex_mem_to_reg;
  logic                  i_id_ex_branch;
  logic [1:0]            i_id_ex_alu_op;
  logic [REG_ADDR_W-1:0] i_mem_wb_rd;
  logic                  i_mem_wb_reg_write;
  logic [XLEN-1:0]       i_mem_wb_write_data;
  logic [XLEN-1:0]       o_ex_mem_alu_result;
  logic [XLEN-1:0]       o_ex_mem_write_data;
  logic [REG_ADDR_W-1:0] o_ex_mem_rd;
  logic                  o_ex_mem_reg_write;
  logic                  o_ex_mem_mem_read;
  logic                  o_ex_mem_mem_write;
  logic                  o_ex_mem_mem_to_reg;
  logic                  o_branch_taken;
  logic [XLEN-1:0]       o_branch_target;

  modport slave (
    input  i_id_ex_pc, i_id_ex_instruction, i_id_ex_read_data1, i_id_ex_read_data2,
           i_id_ex_imm, i_id_ex_rs1, i_id_ex_rs2, i_id_ex_rd, i_id_ex_reg_write,
           i_id_ex_alu_src, i_id_ex_mem_read, i_id_ex_mem_write, i_id_ex_mem_to_reg,
           i_id_ex_branch, i_id_ex_alu_op, i_mem_wb_rd, i_mem_wb_reg_write,
           i_mem_wb_write_data,
    output o_ex_mem_alu_result, o_ex_mem_write_data, o_ex_mem_rd, o_ex_mem_reg_write,
           o_ex_mem_mem_read, o_ex_mem_mem_write, o_ex_mem_mem_to_reg,
           o_branch_taken, o_branch_target
  );

  modport master (
    output i_id_ex_pc, i_id_ex_instruction, i_id_ex_read_data1, i_id_ex_read_data2,
           i_id_ex_imm, i_id_ex_rs1, i_id_ex_rs2, i_id_ex_rd, i_id_ex_reg_write,
           i_id_ex_alu_src, i_id_ex_mem_read, i_id_ex_mem_write, i_id_ex_mem_to_reg,
           i_id_ex_branch, i_id_ex_alu_op, i_mem_wb_rd, i_mem_wb_reg_write,
           i_mem_wb_write_data,
    input  o_ex_mem_alu_result, o_ex_mem_write_data, o_ex_mem_rd, o_ex_mem_reg_write,
           o_ex_mem_mem_read, o_ex_mem_mem_write, o_ex_mem_mem_to_reg,
           o_branch_taken, o_branch_target
  );

endinterface

// File: rtl/alu.sv
// Combinational RV32I integer ALU; shift amounts come from b[4:0].
module alu
  import riscv_pkg::*;
(
  input  alu_ctrl_e       i_ctrl,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result
);

  // Operation select; comparisons return a zero-extended 0/1.
  always_comb begin
    o_result = {XLEN{1'b0}};
    case (i_ctrl)
      ALU_CTRL_ADD:  o_result = i_a + i_b;
      ALU_CTRL_SUB:  o_result = i_a - i_b;
      ALU_CTRL_SLL:  o_result = i_a << i_b[4:0];
      ALU_CTRL_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_CTRL_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      ALU_CTRL_XOR:  o_result = i_a ^ i_b;
      ALU_CTRL_SRL:  o_result = i_a >> i_b[4:0];
      ALU_CTRL_SRA:  o_result = $unsigned($signed(i_a) >>> i_b[4:0]);
      ALU_CTRL_OR:   o_result = i_a | i_b;
      ALU_CTRL_AND:  o_result = i_a & i_b;
      default:       o_result = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU control, branch resolution
// and the EX/MEM pipeline register.
module execute_stage
  import riscv_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_reset,
  execute_stage_if.slave bus
);

  logic [XLEN-1:0]       r_alu_result;
  logic [XLEN-1:0]       r_write_data;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_mem_to_reg;

  fwd_sel_e        w_fwd_a_sel;
  fwd_sel_e        w_fwd_b_sel;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu_result;
  alu_ctrl_e       w_alu_ctrl;
  logic [2:0]      w_funct3;
  logic            w_funct7_b5;
  logic            w_cond;
  logic            w_unused_instr;

  assign w_funct3       = bus.i_id_ex_instruction[14:12];
  assign w_funct7_b5    = bus.i_id_ex_instruction[30];
  assign w_unused_instr = ^{bus.i_id_ex_instruction[31], bus.i_id_ex_instruction[29:15],
                            bus.i_id_ex_instruction[11:0]};

  assign w_fwd_a_sel = fwd_select(bus.i_id_ex_rs1, r_reg_write, r_rd,
                                  bus.i_mem_wb_reg_write, bus.i_mem_wb_rd);
  assign w_fwd_b_sel = fwd_select(bus.i_id_ex_rs2, r_reg_write, r_rd,
                                  bus.i_mem_wb_reg_write, bus.i_mem_wb_rd);

  // Forwarding muxes for both source operands.
  always_comb begin
    w_op_a  = bus.i_id_ex_read_data1;
    w_fwd_b = bus.i_id_ex_read_data2;
    case (w_fwd_a_sel)
      FWD_SEL_EX_MEM: w_op_a = r_alu_result;
      FWD_SEL_MEM_WB: w_op_a = bus.i_mem_wb_write_data;
      default:        w_op_a = bus.i_id_ex_read_data1;
    endcase
    case (w_fwd_b_sel)
      FWD_SEL_EX_MEM: w_fwd_b = r_alu_result;
      FWD_SEL_MEM_WB: w_fwd_b = bus.i_mem_wb_write_data;
      default:        w_fwd_b = bus.i_id_ex_read_data2;
    endcase
  end

  assign w_op_b = bus.i_id_ex_alu_src ? bus.i_id_ex_imm : w_fwd_b;

  // ALU control; funct7[5] selects SUB only for R-type, SRA for both R and I shifts.
  always_comb begin
    w_alu_ctrl = ALU_CTRL_ADD;
    case (bus.i_id_ex_alu_op)
      ALU_OP_ADD:    w_alu_ctrl = ALU_CTRL_ADD;
      ALU_OP_BRANCH: w_alu_ctrl = ALU_CTRL_SUB;
      default: begin
        case (w_funct3)
          FUNCT3_ADD: begin
            if ((bus.i_id_ex_alu_op == ALU_OP_RTYPE) && w_funct7_b5) begin
              w_alu_ctrl = ALU_CTRL_SUB;
            end else begin
              w_alu_ctrl = ALU_CTRL_ADD;
            end
          end
          FUNCT3_SLL:  w_alu_ctrl = ALU_CTRL_SLL;
          FUNCT3_SLT:  w_alu_ctrl = ALU_CTRL_SLT;
          FUNCT3_SLTU: w_alu_ctrl = ALU_CTRL_SLTU;
          FUNCT3_XOR:  w_alu_ctrl = ALU_CTRL_XOR;
          FUNCT3_SR: begin
            if (w_funct7_b5) begin
              w_alu_ctrl = ALU_CTRL_SRA;
            end else begin
              w_alu_ctrl = ALU_CTRL_SRL;
            end
          end
          FUNCT3_OR:   w_alu_ctrl = ALU_CTRL_OR;
          FUNCT3_AND:  w_alu_ctrl = ALU_CTRL_AND;
          default:     w_alu_ctrl = ALU_CTRL_ADD;
        endcase
      end
    endcase
  end

  alu u_alu (
    .i_ctrl   (w_alu_ctrl),
    .i_a      (w_op_a),
    .i_b      (w_op_b),
    .o_result (w_alu_result)
  );

  // Branch condition on forwarded register operands, never the immediate.
  always_comb begin
    w_cond = 1'b0;
    case (w_funct3)
      FUNCT3_BEQ:  w_cond = (w_op_a == w_fwd_b);
      FUNCT3_BNE:  w_cond = (w_op_a != w_fwd_b);
      FUNCT3_BLT:  w_cond = ($signed(w_op_a) < $signed(w_fwd_b));
      FUNCT3_BGE:  w_cond = ($signed(w_op_a) >= $signed(w_fwd_b));
      FUNCT3_BLTU: w_cond = (w_op_a < w_fwd_b);
      FUNCT3_BGEU: w_cond = (w_op_a >= w_fwd_b);
      default:     w_cond = 1'b0;
    endcase
  end

  assign bus.o_branch_taken  = bus.i_id_ex_branch & w_cond & ~i_reset;
  assign bus.o_branch_target = bus.i_id_ex_pc + bus.i_id_ex_imm;

  // EX/MEM register; a branch leaves no architectural side effect downstream.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_alu_result <= {XLEN{1'b0}};
      r_write_data <= {XLEN{1'b0}};
      r_rd         <= {REG_ADDR_W{1'b0}};
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else begin
      r_alu_result <= w_alu_result;
      r_write_data <= w_fwd_b;
      r_rd         <= bus.i_id_ex_rd;
      r_reg_write  <= bus.i_id_ex_reg_write & ~bus.i_id_ex_branch;
      r_mem_read   <= bus.i_id_ex_mem_read & ~bus.i_id_ex_branch;
      r_mem_write  <= bus.i_id_ex_mem_write & ~bus.i_id_ex_branch;
      r_mem_to_reg <= bus.i_id_ex_mem_to_reg;
    end
  end

  assign bus.o_ex_mem_alu_result = r_alu_result;
  assign bus.o_ex_mem_write_data = r_write_data;
  assign bus.o_ex_mem_rd         = r_rd;
  assign bus.o_ex_mem_reg_write  = r_reg_write;
  assign bus.o_ex_mem_mem_read   = r_mem_read;
  assign bus.o_ex_mem_mem_write  = r_mem_write;
  assign bus.o_ex_mem_mem_to_reg = r_mem_to_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed spec cases, then random
// instructions against an instruction-level reference model.
module tb_execute_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_stage_if bus ();

  execute_stage dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected EX/MEM contents (what the next stage should currently see).
  logic [31:0] m_res, m_wd;
  logic [4:0]  m_rd;
  logic        m_rw, m_mr, m_mw, m_m2r;

  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_STD = 7'b0000000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 10'h0, f3, 12'h0};
  endfunction

  // Value an instruction in EX sees for register rs: newest in-flight write first.
  function automatic logic [31:0] ref_src(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return rf;
    if (m_rw && m_rd == rs) return m_res;
    if (bus.i_mem_wb_reg_write && bus.i_mem_wb_rd == rs) return bus.i_mem_wb_write_data;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] instr,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [2:0] f3;
    logic       alt;
    f3  = instr[14:12];
    alt = instr[30];
    if (op == 2'b00) return a + b;
    if (op == 2'b01) return a - b;
    case (f3)
      3'b000:  return (op == 2'b10 && alt) ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return a ^ b;
      3'b101:  return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] pc, instr, rd1, rd2, imm,
                       input logic [4:0] rs1, rs2, rd,
                       input logic rw, src, mr, mw, m2r, br, input logic [1:0] op,
                       input logic [4:0] wbrd, input logic wbrw, input logic [31:0] wbdata);
    bus.i_id_ex_pc          = pc;
    bus.i_id_ex_instruction = instr;
    bus.i_id_ex_read_data1  = rd1;
    bus.i_id_ex_read_data2  = rd2;
    bus.i_id_ex_imm         = imm;
    bus.i_id_ex_rs1         = rs1;
    bus.i_id_ex_rs2         = rs2;
    bus.i_id_ex_rd          = rd;
    bus.i_id_ex_reg_write   = rw;
    bus.i_id_ex_alu_src     = src;
    bus.i_id_ex_mem_read    = mr;
    bus.i_id_ex_mem_write   = mw;
    bus.i_id_ex_mem_to_reg  = m2r;
    bus.i_id_ex_branch      = br;
    bus.i_id_ex_alu_op      = op;
    bus.i_mem_wb_rd         = wbrd;
    bus.i_mem_wb_reg_write  = wbrw;
    bus.i_mem_wb_write_data = wbdata;
  endtask

  task automatic chk_exmem(input string tag);
    chk({tag, "_res"}, bus.o_ex_mem_alu_result, m_res);
    chk({tag, "_wd"},  bus.o_ex_mem_write_data, m_wd);
    chk({tag, "_rd"},  {27'd0, bus.o_ex_mem_rd}, {27'd0, m_rd});
    chk({tag, "_ctl"}, {28'd0, bus.o_ex_mem_reg_write, bus.o_ex_mem_mem_read,
                        bus.o_ex_mem_mem_write, bus.o_ex_mem_mem_to_reg},
                       {28'd0, m_rw, m_mr, m_mw, m_m2r});
  endtask

  task automatic clear_model();
    m_res = 32'd0; m_wd = 32'd0; m_rd = 5'd0;
    m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0;
  endtask

  // One instruction through EX: check redirect before the edge, EX/MEM after it.
  task automatic step(input string tag, input logic [31:0] pc, instr, rd1, rd2, imm,
                      input logic [4:0] rs1, rs2, rd,
                      input logic rw, src, mr, mw, m2r, br, input logic [1:0] op,
                      input logic [4:0] wbrd, input logic wbrw, input logic [31:0] wbdata);
    logic [31:0] a, b, res;
    logic        tk;
    drive(pc, instr, rd1, rd2, imm, rs1, rs2, rd, rw, src, mr, mw, m2r, br, op,
          wbrd, wbrw, wbdata);
    #1;
    a   = ref_src(rs1, rd1);
    b   = ref_src(rs2, rd2);
    res = ref_alu(op, instr, a, src ? imm : b);
    tk  = br && ref_taken(instr[14:12], a, b);
    chk({tag, "_taken"}, {31'd0, bus.o_branch_taken}, {31'd0, tk});
    chk({tag, "_target"}, bus.o_branch_target, pc + imm);
    @(posedge clk);
    #1;
    m_res = res; m_wd = b; m_rd = rd;
    m_rw = rw & ~br; m_mr = mr & ~br; m_mw = mw & ~br; m_m2r = m2r;
    chk_exmem(tag);
  endtask

  initial begin
    logic [31:0] t_pc, t_instr, t_rd1, t_rd2, t_imm, t_wbd;
    logic [4:0]  t_rs1, t_rs2, t_rd, t_wbrd;
    logic        t_rw, t_src, t_mr, t_mw, t_m2r, t_br, t_wbrw;
    logic [1:0]  t_op;

    // Reset with busy, branch-taking inputs present.
    rst = 1'b1;
    drive(32'h40, mk(F7_STD, 3'b000), 32'h55, 32'h55, 32'h8, 5'd1, 5'd2, 5'd3,
          1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 5'd1, 1'b1, 32'h99);
    #12;
    clear_model();
    chk_exmem("reset");
    chk("reset_taken", {31'd0, bus.o_branch_taken}, 32'd0);
    rst = 1'b0;

    step("add", 32'h0, mk(F7_STD, 3'b000), 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd0, 1'b0, 32'd0);
    chk("add_exact", bus.o_ex_mem_alu_result, 32'd12);
    step("sub_fwd", 32'h4, mk(F7_ALT, 3'b000), 32'd0, 32'd5, 32'd0, 5'd3, 5'd1, 5'd4,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd0, 1'b0, 32'd0);
    chk("sub_fwd_exact", bus.o_ex_mem_alu_result, 32'd7);
    step("addi_x5", 32'h8, mk(F7_STD, 3'b000), 32'd0, 32'd0, 32'd4, 5'd0, 5'd0, 5'd5,
         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 5'd0, 1'b0, 32'd0);
    step("prio", 32'hC, mk(F7_STD, 3'b000), 32'd0, 32'd0, 32'd1, 5'd5, 5'd0, 5'd6,
         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 5'd5, 1'b1, 32'd9);
    chk("prio_exact", bus.o_ex_mem_alu_result, 32'd5);
    step("addi_x0", 32'h10, mk(F7_STD, 3'b000), 32'd77, 32'd0, 32'd0, 5'd1, 5'd0, 5'd0,
         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 5'd0, 1'b0, 32'd0);
    step("x0_nofwd", 32'h14, mk(F7_STD, 3'b000), 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd7,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd0, 1'b1, 32'd55);
    chk("x0_nofwd_exact", bus.o_ex_mem_alu_result, 32'd0);
    step("blt", 32'h100, mk(F7_STD, 3'b100), 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd10, 5'd11, 5'd9,
         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 5'd0, 1'b0, 32'd0);
    chk("blt_taken_exact", {31'd0, bus.o_branch_taken}, 32'd1);
    chk("blt_target_exact", bus.o_branch_target, 32'h120);
    step("bltu", 32'h100, mk(F7_STD, 3'b110), 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd10, 5'd11, 5'd9,
         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 5'd0, 1'b0, 32'd0);
    chk("bltu_taken_exact", {31'd0, bus.o_branch_taken}, 32'd0);
    step("sra", 32'h18, mk(F7_ALT, 3'b101), 32'h8000_0000, 32'd4, 32'd0, 5'd12, 5'd13, 5'd8,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd0, 1'b0, 32'd0);
    chk("sra_exact", bus.o_ex_mem_alu_result, 32'hF800_0000);
    step("srl", 32'h1C, mk(F7_STD, 3'b101), 32'h8000_0000, 32'd4, 32'd0, 5'd12, 5'd13, 5'd8,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd0, 1'b0, 32'd0);
    chk("srl_exact", bus.o_ex_mem_alu_result, 32'h0800_0000);
    step("sltu", 32'h20, mk(F7_STD, 3'b011), 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd14, 5'd15, 5'd9,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd0, 1'b0, 32'd0);
    chk("sltu_exact", bus.o_ex_mem_alu_result, 32'd0);
    step("srai", 32'h24, mk(F7_ALT, 3'b101), 32'h8000_0000, 32'd0, 32'h404, 5'd16, 5'd0, 5'd10,
         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 5'd0, 1'b0, 32'd0);
    chk("srai_exact", bus.o_ex_mem_alu_result, 32'hF800_0000);
    step("addi_b30", 32'h28, mk(F7_ALT, 3'b000), 32'd10, 32'd0, 32'h400, 5'd17, 5'd0, 5'd11,
         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 5'd0, 1'b0, 32'd0);
    chk("addi_b30_exact", bus.o_ex_mem_alu_result, 32'h40A);

    for (int k = 0; k < 400; k++) begin
      t_pc    = $urandom & 32'hFFFF_FFFC;
      t_instr = $urandom;
      t_rd1   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      t_rd2   = ($urandom_range(0, 3) == 0) ? t_rd1 : $urandom;
      t_imm   = $urandom;
      t_rs1   = 5'($urandom_range(0, 7));
      t_rs2   = 5'($urandom_range(0, 7));
      t_rd    = 5'($urandom_range(0, 7));
      t_br    = ($urandom_range(0, 3) == 0);
      t_op    = t_br ? 2'b01 : 2'($urandom_range(0, 3));
      t_src   = t_br ? 1'b0 : 1'($urandom_range(0, 1));
      t_rw    = 1'($urandom_range(0, 1));
      t_mr    = t_rw ? 1'b0 : 1'($urandom_range(0, 1));
      t_mw    = 1'($urandom_range(0, 1));
      t_m2r   = 1'($urandom_range(0, 1));
      t_wbrd  = 5'($urandom_range(0, 7));
      t_wbrw  = 1'($urandom_range(0, 1));
      t_wbd   = $urandom;
      step("rand", t_pc, t_instr, t_rd1, t_rd2, t_imm, t_rs1, t_rs2, t_rd, t_rw, t_src,
           t_mr, t_mw, t_m2r, t_br, t_op, t_wbrd, t_wbrw, t_wbd);
    end

    // Reset arriving mid-cycle with a taken branch in EX.
    step("pre_rst", 32'h30, mk(F7_STD, 3'b110), 32'h1234, 32'h1, 32'd0, 5'd20, 5'd21, 5'd12,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 5'd0, 1'b0, 32'd0);
    drive(32'h200, mk(F7_STD, 3'b000), 32'h7, 32'h7, 32'h10, 5'd22, 5'd23, 5'd0,
          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 5'd0, 1'b0, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    clear_model();
    chk_exmem("midrst");
    chk("midrst_taken", {31'd0, bus.o_branch_taken}, 32'd0);
    #1;
    rst = 1'b0;
    step("post_rst", 32'h204, mk(F7_STD, 3'b000), 32'd20, 32'd22, 32'd0, 5'd12, 5'd13, 5'd14,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd0, 1'b0, 32'd0);
    chk("post_rst_exact", bus.o_ex_mem_alu_result, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
